// File: rtl/sipo_framed_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_framed_rx
// Purpose  : Framed serial-in/parallel-out receiver with a one-word holding
//            register and a valid/ready handshake. Defining SIPO_RX_PARITY_EN
//            adds one trailing even-parity bit per frame.
// Revision : 1.0  initial release
// ============================================================================
module sipo_framed_rx #(
    parameter int   OUTPUT_WIDTH = 8,
    parameter int   SHIFT_LEFT   = 1,
    parameter logic VALUE_PULL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    serial_in,
    input  logic                    frame_start,
    output logic [OUTPUT_WIDTH-1:0] data,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    overrun,
    output logic                    parity_err
);

    localparam int                       c_cnt_w = $clog2(OUTPUT_WIDTH);
    localparam logic [c_cnt_w-1:0]       c_last  = c_cnt_w'(OUTPUT_WIDTH - 1);
    localparam logic [OUTPUT_WIDTH-1:0]  c_fill  = {OUTPUT_WIDTH{VALUE_PULL}};

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OUTPUT_WIDTH-1:0] r_shift;
    logic [OUTPUT_WIDTH-1:0] w_shift_next;
    logic [OUTPUT_WIDTH-1:0] w_shifted;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_next;
    logic                    w_done;
    logic [OUTPUT_WIDTH-1:0] w_word;
    logic                    w_perr;
    logic [OUTPUT_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_ovr;
    logic                    w_unused;

    generate
        if (SHIFT_LEFT != 0) begin : g_shift_left
            assign w_shifted = {r_shift[OUTPUT_WIDTH-2:0], serial_in};
        end else begin : g_shift_right
            assign w_shifted = {serial_in, r_shift[OUTPUT_WIDTH-1:1]};
        end
    endgenerate

    // Without parity the bit shifted out of the register is never observed.
    assign w_unused = ^r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= c_fill;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // frame_start takes priority in every state, including the completion edge.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        w_word       = w_shifted;
        w_perr       = 1'b0;
        if (frame_start) begin
            w_state_next = S_SHIFT;
            w_shift_next = c_fill;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    w_shift_next = w_shifted;
                    w_cnt_next   = r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        w_cnt_next = '0;
`ifdef SIPO_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_IDLE;
                        w_done       = 1'b1;
`endif
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                S_PARITY: begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                    w_word       = r_shift;
                    w_perr       = ^{r_shift, serial_in};
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef SIPO_RX_PARITY_EN
    logic r_perr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_ovr <= 1'b0;
            if (w_done) begin
                if (!r_valid || data_ready) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
                    r_perr  <= w_perr;
`endif
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_ovr;
`ifdef SIPO_RX_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
    logic w_unused_perr;
    assign w_unused_perr = w_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_framed_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_framed_rx
// Purpose  : Self-checking bench for sipo_framed_rx, MSB-first and LSB-first
//            instances driven from one serial stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_sipo_framed_rx;

    localparam int W = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         frame_start;
    logic         data_ready;
    logic [W-1:0] data_l, data_r;
    logic         valid_l, valid_r, ovr_l, ovr_r, perr_l, perr_r;

    logic [W-1:0] m_data_l, m_data_r;
    logic         m_valid, m_ovr, m_perr;
    int           n_vec = 0;
    int           n_err = 0;

    sipo_framed_rx #(.OUTPUT_WIDTH(W), .SHIFT_LEFT(1), .VALUE_PULL(1'b0)) u_dut_l (
        .clk(clk), .reset(reset), .serial_in(serial_in), .frame_start(frame_start),
        .data(data_l), .data_valid(valid_l), .data_ready(data_ready),
        .overrun(ovr_l), .parity_err(perr_l)
    );

    sipo_framed_rx #(.OUTPUT_WIDTH(W), .SHIFT_LEFT(0), .VALUE_PULL(1'b1)) u_dut_r (
        .clk(clk), .reset(reset), .serial_in(serial_in), .frame_start(frame_start),
        .data(data_r), .data_valid(valid_r), .data_ready(data_ready),
        .overrun(ovr_r), .parity_err(perr_r)
    );

    always #5 clk = ~clk;

    // tx[i] is the i-th bit on the wire; MSB-first puts it at weight 2^(W-1-i).
    function automatic logic [W-1:0] word_l(input logic [W-1:0] tx);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) w = w | (W'(tx[i]) << (W - 1 - i));
        return w;
    endfunction

    // One clock of stimulus; the reference model applies the handshake rules.
    task automatic step(input logic fs, input logic sin, input logic rdy,
                        input logic done, input logic [W-1:0] wl,
                        input logic [W-1:0] wr, input logic pe);
        frame_start = fs;
        serial_in   = sin;
        data_ready  = rdy;
        @(posedge clk);
        if (reset) begin
            m_data_l = '0; m_data_r = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            m_ovr = 1'b0;
            if (done && !fs) begin
                if (!m_valid || rdy) begin
                    m_data_l = wl; m_data_r = wr; m_perr = pe; m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] tx, input logic pbit,
                              input logic rdy_body, input logic rdy_last);
        step(1'b1, 1'b0, rdy_body, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1 && PAR == 0)
                step(1'b0, tx[i], rdy_last, 1'b1, word_l(tx), tx, 1'b0);
            else
                step(1'b0, tx[i], rdy_body, 1'b0, '0, '0, 1'b0);
        end
        if (PAR != 0) step(1'b0, pbit, rdy_last, 1'b1, word_l(tx), tx, (^tx) ^ pbit);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        n_vec++;
        if ({data_l, data_r} !== '0) begin
            $display("FAIL reset_data: got %h/%h want 00/00", data_l, data_r); n_err++;
        end
        n_vec++;
        if ({valid_l, valid_r, ovr_l, ovr_r, perr_l, perr_r} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000",
                     {valid_l, valid_r, ovr_l, ovr_r, perr_l, perr_r}); n_err++;
        end
    endtask

    task automatic test_msb_first;
        send_frame(8'b0001_1011, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (data_l !== 8'hD8 || valid_l !== 1'b1) begin
            $display("FAIL msb_first: got %h v=%b want d8 v=1", data_l, valid_l); n_err++;
        end
        n_vec++;
        if (data_r !== m_data_r || valid_r !== 1'b1) begin
            $display("FAIL lsb_first_a: got %h v=%b want %h v=1", data_r, valid_r, m_data_r); n_err++;
        end
    endtask

    task automatic test_overrun;
        send_frame(8'b0010_1000, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (ovr_l !== 1'b1 || ovr_r !== 1'b1 || data_l !== 8'hD8 || valid_l !== 1'b1) begin
            $display("FAIL overrun_pulse: got ovr=%b data=%h v=%b want ovr=1 data=d8 v=1",
                     ovr_l, data_l, valid_l); n_err++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        n_vec++;
        if (ovr_l !== 1'b0 || data_l !== 8'hD8 || valid_l !== 1'b1) begin
            $display("FAIL overrun_width: got ovr=%b data=%h v=%b want ovr=0 data=d8 v=1",
                     ovr_l, data_l, valid_l); n_err++;
        end
    endtask

    task automatic test_replace;
        send_frame(8'b0010_1000, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (data_r !== 8'h28 || data_l !== 8'h14 || valid_r !== 1'b1 || ovr_r !== 1'b0) begin
            $display("FAIL replace: got %h/%h v=%b ovr=%b want 14/28 v=1 ovr=0",
                     data_l, data_r, valid_r, ovr_r); n_err++;
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        n_vec++;
        if (valid_r !== 1'b0 || data_r !== 8'h28) begin
            $display("FAIL consume: got v=%b data=%h want v=0 data=28", valid_r, data_r); n_err++;
        end
    endtask

    task automatic test_abort;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);
            n_vec++;
            if (valid_l !== 1'b0 || valid_r !== 1'b0 || data_l !== 8'h00) begin
                $display("FAIL idle_after_reset: got v=%b data=%h want v=0 data=00",
                         valid_l, data_l); n_err++;
            end
        end
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (data_l !== 8'hA5 || data_r !== 8'hA5 || valid_l !== 1'b1) begin
            $display("FAIL post_reset_frame: got %h/%h v=%b want a5/a5 v=1",
                     data_l, data_r, valid_l); n_err++;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (data_l !== 8'h3C || data_r !== 8'h3C || ovr_l !== 1'b0 || valid_l !== 1'b1) begin
            $display("FAIL restart_frame: got %h/%h ovr=%b v=%b want 3c/3c ovr=0 v=1",
                     data_l, data_r, ovr_l, valid_l); n_err++;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_parity;
`ifdef SIPO_RX_PARITY_EN
        send_frame(8'b0001_1011, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (data_l !== 8'hD8 || perr_l !== 1'b1 || perr_r !== 1'b1) begin
            $display("FAIL parity_bad: got data=%h perr=%b want data=d8 perr=1", data_l, perr_l); n_err++;
        end
        send_frame(8'b0001_1011, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (data_l !== 8'hD8 || perr_l !== 1'b0 || perr_r !== 1'b0) begin
            $display("FAIL parity_good: got data=%h perr=%b want data=d8 perr=0", data_l, perr_l); n_err++;
        end
`else
        send_frame(8'b0001_1011, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (data_l !== 8'hD8 || perr_l !== 1'b0 || perr_r !== 1'b0) begin
            $display("FAIL parity_tied: got data=%h perr=%b want data=d8 perr=0", data_l, perr_l); n_err++;
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] tx;
        for (int f = 0; f < 5; f++) begin
            tx = W'($urandom);
            send_frame(tx, 1'($urandom), 1'b1, 1'b1);
            n_vec++;
            if (data_l !== word_l(tx) || data_r !== tx || ovr_l !== 1'b0 || valid_l !== 1'b1) begin
                $display("FAIL back_to_back: got %h/%h ovr=%b v=%b want %h/%h ovr=0 v=1",
                         data_l, data_r, ovr_l, valid_l, word_l(tx), tx); n_err++;
            end
        end
    endtask

    task automatic test_random;
        int           pos;
        logic [W-1:0] tx;
        logic         pbit, fs, sin, rdy, done;
        logic [2*W+5:0] act, exp;
        pos  = -1;
        tx   = '0;
        pbit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            fs   = ($urandom_range(0, 14) == 0) || (pos < 0 && $urandom_range(0, 3) == 0);
            sin  = 1'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            done = 1'b0;
            if (fs) begin
                pos = 0;
                tx  = '0;
            end else if (pos >= 0) begin
                if (pos < W) tx[pos] = sin;
                else         pbit    = sin;
                pos++;
                if (pos == W + PAR) begin
                    done = 1'b1;
                    pos  = -1;
                end
            end
            step(fs, sin, rdy, done, word_l(tx), tx, (PAR != 0) ? ((^tx) ^ pbit) : 1'b0);
            act = {data_l, data_r, valid_l, valid_r, ovr_l, ovr_r, perr_l, perr_r};
            exp = {m_data_l, m_data_r, m_valid, m_valid, m_ovr, m_ovr, m_perr, m_perr};
            n_vec++;
            if (act !== exp) begin
                $display("FAIL random cyc=%0d: got %h want %h", c, act, exp); n_err++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
        m_data_l = '0; m_data_r = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        test_reset();
        test_msb_first();
        test_overrun();
        test_replace();
        test_abort();
        test_parity();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
